// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package    : cpu_pkg
// Description: Shared definitions for the 8-bit RISC core: opcodes (also used
//              by the ALU), controller state encoding and instruction fields.
// Revision   : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Datapath widths
  localparam int CPU_PC_W    = 8;
  localparam int CPU_INSTR_W = 16;

  // Opcodes (shared with the ALU)
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_CMP   = 4'b0101;
  localparam logic [3:0] OP_LOAD  = 4'b0110;
  localparam logic [3:0] OP_STORE = 4'b0111;
  localparam logic [3:0] OP_BEQ   = 4'b1000;
  localparam logic [3:0] OP_JMP   = 4'b1001;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // ALU operation used to form the rs1+rs2 data address for LOAD/STORE
  localparam logic [3:0] ALU_OP_ADDR = 4'b0110;

  // Instruction field positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 8;
  localparam int RS2_MSB = 7;
  localparam int RS2_LSB = 6;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Controller state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_FETCH     = 3'd0;
  localparam state_t ST_DECODE    = 3'd1;
  localparam state_t ST_EXECUTE   = 3'd2;
  localparam state_t ST_MEM       = 3'd3;
  localparam state_t ST_WRITEBACK = 3'd4;
  localparam state_t ST_HALT      = 3'd5;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
// Module     : instr_decode
// Description: Combinational instruction decoder: splits the IR into its
//              register/immediate fields and classifies the opcode.
// Revision   : 1.0 - initial release
// ============================================================================
module instr_decode
  import cpu_pkg::*;
(
  input  logic [CPU_INSTR_W-1:0] ir_i,
  output logic [3:0]             op_o,
  output logic                   is_rtype_o,
  output logic                   is_cmp_o,
  output logic                   is_mem_o,
  output logic                   is_load_o,
  output logic                   is_store_o,
  output logic                   is_branch_o,
  output logic                   is_jmp_o,
  output logic                   is_halt_o,
  output logic                   is_illegal_o,
  output logic [1:0]             rd_o,
  output logic [1:0]             rs1_o,
  output logic [1:0]             rs2_o,
  output logic [7:0]             imm_o
);

  assign op_o  = ir_i[OP_MSB:OP_LSB];
  assign rd_o  = ir_i[RD_MSB:RD_LSB];
  assign rs1_o = ir_i[RS1_MSB:RS1_LSB];
  assign rs2_o = ir_i[RS2_MSB:RS2_LSB];
  assign imm_o = ir_i[IMM_MSB:IMM_LSB];

  // Opcode classification; anything not listed is illegal and runs as a NOP
  always_comb begin
    is_rtype_o   = 1'b0;
    is_cmp_o     = 1'b0;
    is_load_o    = 1'b0;
    is_store_o   = 1'b0;
    is_branch_o  = 1'b0;
    is_jmp_o     = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;
    case (op_o)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: is_rtype_o  = 1'b1;
      OP_CMP:                                is_cmp_o    = 1'b1;
      OP_LOAD:                               is_load_o   = 1'b1;
      OP_STORE:                              is_store_o  = 1'b1;
      OP_BEQ:                                is_branch_o = 1'b1;
      OP_JMP:                                is_jmp_o    = 1'b1;
      OP_HALT:                               is_halt_o   = 1'b1;
      default:                               is_illegal_o = 1'b1;
    endcase
  end

  assign is_mem_o = is_load_o | is_store_o;

endmodule : instr_decode
`default_nettype wire

// File: rtl/alu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module     : alu_ctrl_fsm
// Description: Multi-cycle fetch/decode/execute controller. Fetches 16-bit
//              instructions, steers the ALU, sequences register-file and
//              data-memory accesses, owns the PC and the compare flag.
// Revision   : 1.0 - initial release
// ============================================================================
module alu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int PC_W    = CPU_PC_W,
  parameter int INSTR_W = CPU_INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  // instruction memory
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  // ALU
  output logic [3:0]         alu_opcode,
  output logic               alu_src,
  input  logic               alu_compare,
  // register file
  output logic [1:0]         rf_raddr1,
  output logic [1:0]         rf_raddr2,
  output logic               rf_we,
  output logic [1:0]         rf_waddr,
  output logic               rf_wsel,
  // data memory
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ready,
  // status
  output logic               halted,
  output logic               illegal
);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               flag_q, flag_d;
  // Low while reset is asserted and until the first clock edge after release,
  // so no fetch request is visible during reset.
  logic               run_q;

  logic [3:0] dec_op;
  logic       dec_is_rtype, dec_is_cmp, dec_is_mem, dec_is_load, dec_is_store;
  logic       dec_is_branch, dec_is_jmp, dec_is_halt, dec_is_illegal;
  logic [1:0] dec_rd, dec_rs1, dec_rs2;
  logic [7:0] dec_imm;
  logic       alu_phase;

  instr_decode u_decode (
    .ir_i         (ir_q),
    .op_o         (dec_op),
    .is_rtype_o   (dec_is_rtype),
    .is_cmp_o     (dec_is_cmp),
    .is_mem_o     (dec_is_mem),
    .is_load_o    (dec_is_load),
    .is_store_o   (dec_is_store),
    .is_branch_o  (dec_is_branch),
    .is_jmp_o     (dec_is_jmp),
    .is_halt_o    (dec_is_halt),
    .is_illegal_o (dec_is_illegal),
    .rd_o         (dec_rd),
    .rs1_o        (dec_rs1),
    .rs2_o        (dec_rs2),
    .imm_o        (dec_imm)
  );

  // Next-state, PC, IR and flag update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flag_d  = flag_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_req && imem_ready) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_is_jmp) begin
          pc_d    = PC_W'(dec_imm);
          state_d = ST_FETCH;
        end else if (dec_is_branch) begin
          // Target overrides the increment applied during FETCH
          if (flag_q) pc_d = PC_W'(dec_imm);
          state_d = ST_FETCH;
        end else if (dec_is_halt) begin
          state_d = ST_HALT;
        end else if (dec_is_illegal) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (dec_is_cmp) begin
          flag_d  = alu_compare;
          state_d = ST_FETCH;
        end else if (dec_is_mem) begin
          state_d = ST_MEM;
        end else if (dec_is_rtype) begin
          state_d = ST_WRITEBACK;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (dmem_req && dmem_ready) begin
          state_d = dec_is_load ? ST_WRITEBACK : ST_FETCH;
        end
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_FETCH;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      flag_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flag_q  <= flag_d;
      run_q   <= 1'b1;
    end
  end

  // Moore outputs decoded from the state register and IR. The ALU stays
  // enabled through MEM and WRITEBACK so its result (address or write data)
  // remains stable.
  assign alu_phase  = (state_q == ST_EXECUTE) || (state_q == ST_MEM) ||
                      (state_q == ST_WRITEBACK);

  assign imem_req   = run_q && (state_q == ST_FETCH);
  assign imem_addr  = pc_q;
  assign alu_src    = alu_phase;
  assign alu_opcode = alu_phase ? (dec_is_mem ? ALU_OP_ADDR : dec_op) : 4'b0000;
  assign rf_raddr1  = dec_rs1;
  // During a STORE's MEM phase port 2 reads rd to supply the store data
  assign rf_raddr2  = ((state_q == ST_MEM) && dec_is_store) ? dec_rd : dec_rs2;
  assign rf_we      = (state_q == ST_WRITEBACK);
  assign rf_waddr   = dec_rd;
  assign rf_wsel    = rf_we && dec_is_load;
  assign dmem_req   = (state_q == ST_MEM);
  assign dmem_we    = dmem_req && dec_is_store;
  assign halted     = (state_q == ST_HALT);
  assign illegal    = (state_q == ST_DECODE) && dec_is_illegal;

endmodule : alu_ctrl_fsm
`default_nettype wire

// File: tb/tb_alu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module     : tb_alu_ctrl_fsm
// Description: Self-checking bench for alu_ctrl_fsm. An instruction-level
//              reference model predicts latency, strobe counts and the next
//              fetch address for each instruction.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ready;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [3:0]  alu_opcode;
  logic        alu_src, alu_compare;
  logic [1:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic        rf_we, rf_wsel;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        halted, illegal;

  int errors = 0;
  int checks = 0;

  // Architectural model state
  logic [7:0] m_pc;
  bit         m_flag;

  always #5 clk = ~clk;

  alu_ctrl_fsm #(.PC_W(8), .INSTR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .alu_opcode(alu_opcode), .alu_src(alu_src), .alu_compare(alu_compare),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wsel(rf_wsel),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .halted(halted), .illegal(illegal)
  );

  // Runs one instruction from its first FETCH cycle to the next FETCH (or
  // HALT) and compares what was observed against the instruction model.
  task automatic exec_instr(input logic [15:0] instr, input int iw, input int dw,
                            input bit cmpv, input string tag);
    logic [3:0] op;
    logic [1:0] rd, rs1, rs2, we_addr;
    logic [7:0] imm, npc;
    logic [3:0] exp_aluop;
    bit is_alu, is_cmp, is_ld, is_st, is_beq, is_jmp, is_halt, is_nop;
    bit exp_we, we_sel, fetched, timeout;
    int exp_lat, exp_dreq, exp_dwe, exp_src, exp_ill;
    int cycles, iwaited, dwaited, n_we, n_dreq, n_dwe, n_ill, n_src, bad_bus, bad_fetch;
    op = instr[15:12]; rd = instr[11:10]; rs1 = instr[9:8]; rs2 = instr[7:6]; imm = instr[7:0];
    is_alu = (op <= 4'd4); is_cmp = (op == 4'd5); is_ld = (op == 4'd6); is_st = (op == 4'd7);
    is_beq = (op == 4'd8); is_jmp = (op == 4'd9); is_halt = (op == 4'd15);
    is_nop = !(is_alu || is_cmp || is_ld || is_st || is_beq || is_jmp || is_halt);
    // Latency rules: base cost per class plus every wait cycle
    if (is_alu)      exp_lat = 4 + iw;
    else if (is_cmp) exp_lat = 3 + iw;
    else if (is_ld)  exp_lat = 5 + iw + dw;
    else if (is_st)  exp_lat = 4 + iw + dw;
    else             exp_lat = 2 + iw;
    exp_we    = is_alu || is_ld;
    exp_dreq  = (is_ld || is_st) ? dw + 1 : 0;
    exp_dwe   = is_st ? dw + 1 : 0;
    exp_ill   = is_nop ? 1 : 0;
    exp_src   = is_alu ? 2 : is_cmp ? 1 : is_ld ? dw + 3 : is_st ? dw + 2 : 0;
    exp_aluop = (is_ld || is_st) ? 4'b0110 : op;
    npc = m_pc + 8'd1;
    if (is_jmp || (is_beq && m_flag)) npc = imm;

    cycles = 0; iwaited = 0; dwaited = 0; n_we = 0; n_dreq = 0; n_dwe = 0;
    n_ill = 0; n_src = 0; bad_bus = 0; bad_fetch = 0; we_addr = 2'd0; we_sel = 1'b0;
    fetched = 1'b0; timeout = 1'b0;

    checks++;
    if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
      errors++;
      $display("FAIL %s start: req=%0b addr=%02h expected req=1 addr=%02h", tag, imem_req, imem_addr, m_pc);
    end

    while (1) begin
      if (fetched && (imem_req || halted)) break;
      if (cycles > 80) begin timeout = 1'b1; break; end
      // observe this cycle's outputs
      if (rf_we) begin n_we++; we_addr = rf_waddr; we_sel = rf_wsel; end
      if (dmem_req) n_dreq++;
      if (dmem_we)  n_dwe++;
      if (illegal)  n_ill++;
      if (alu_src) begin
        n_src++;
        if (alu_opcode !== exp_aluop || rf_raddr1 !== rs1 ||
            rf_raddr2 !== ((dmem_req && is_st) ? rd : rs2)) bad_bus++;
      end
      if (dmem_req && (alu_src !== 1'b1 || alu_opcode !== 4'b0110)) bad_bus++;
      if (!fetched && (imem_req !== 1'b1 || imem_addr !== m_pc)) bad_fetch++;
      // drive responses; stray readies without a request must be ignored
      if (!fetched && imem_req) begin
        if (iwaited < iw) begin imem_ready = 1'b0; imem_rdata = 16'($urandom); iwaited++; end
        else begin imem_ready = 1'b1; imem_rdata = instr; fetched = 1'b1; end
      end else begin
        imem_ready = 1'($urandom); imem_rdata = 16'($urandom);
      end
      if (dmem_req) begin
        if (dwaited < dw) begin dmem_ready = 1'b0; dwaited++; end
        else dmem_ready = 1'b1;
      end else begin
        dmem_ready = 1'($urandom);
      end
      alu_compare = alu_src ? cmpv : 1'($urandom);
      @(posedge clk); #1;
      cycles++;
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;

    checks++;
    if (timeout) begin errors++; $display("FAIL %s timeout: no next fetch within %0d cycles", tag, cycles); end
    checks++;
    if (cycles != exp_lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", tag, cycles, exp_lat); end
    checks++;
    if (n_we != (exp_we ? 1 : 0)) begin errors++; $display("FAIL %s rf_we count: got %0d expected %0d", tag, n_we, exp_we ? 1 : 0); end
    if (exp_we) begin
      checks++;
      if (we_addr !== rd || we_sel !== is_ld) begin
        errors++;
        $display("FAIL %s writeback: waddr=%0d wsel=%0b expected waddr=%0d wsel=%0b", tag, we_addr, we_sel, rd, is_ld);
      end
    end
    checks++;
    if (n_dreq != exp_dreq || n_dwe != exp_dwe) begin
      errors++;
      $display("FAIL %s dmem: req=%0d we=%0d cycles expected req=%0d we=%0d", tag, n_dreq, n_dwe, exp_dreq, exp_dwe);
    end
    checks++;
    if (n_ill != exp_ill) begin errors++; $display("FAIL %s illegal pulses: got %0d expected %0d", tag, n_ill, exp_ill); end
    checks++;
    if (n_src != exp_src) begin errors++; $display("FAIL %s alu_src cycles: got %0d expected %0d", tag, n_src, exp_src); end
    checks++;
    if (bad_bus != 0 || bad_fetch != 0) begin
      errors++;
      $display("FAIL %s bus values: bad alu/rf cycles=%0d bad fetch cycles=%0d expected 0/0", tag, bad_bus, bad_fetch);
    end
    m_pc = npc;
    if (is_cmp) m_flag = cmpv;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; alu_compare = 1'b0; imem_rdata = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({imem_req, alu_src, rf_we, dmem_req, dmem_we, halted, illegal} !== 7'b0) begin
      errors++;
      $display("FAIL reset strobes: got %07b expected 0000000",
               {imem_req, alu_src, rf_we, dmem_req, dmem_we, halted, illegal});
    end
    checks++;
    if (alu_opcode !== 4'h0 || rf_wsel !== 1'b0) begin
      errors++; $display("FAIL reset alu_opcode/wsel: got %h/%0b expected 0/0", alu_opcode, rf_wsel);
    end
    checks++;
    if (imem_addr !== 8'h0 || rf_raddr1 !== 2'd0 || rf_raddr2 !== 2'd0 || rf_waddr !== 2'd0) begin
      errors++;
      $display("FAIL reset addresses: imem=%02h r1=%0d r2=%0d w=%0d expected all 0", imem_addr, rf_raddr1, rf_raddr2, rf_waddr);
    end
    rst_n = 1'b1;
    m_pc = 8'h00; m_flag = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset release req: got %0b expected 0", imem_req); end
    @(posedge clk); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      errors++; $display("FAIL first fetch: req=%0b addr=%02h expected 1/00", imem_req, imem_addr);
    end
  endtask

  task automatic test_add();
    exec_instr(16'h06C0, 0, 0, 1'b0, "add_r1_r2_r3");
    exec_instr(16'h1E40, 1, 0, 1'b0, "sub_wait");
  endtask

  task automatic test_branch();
    logic [7:0] beq_pc;
    exec_instr(16'h5240, 0, 0, 1'b1, "cmp_eq");
    exec_instr(16'h8040, 0, 0, 1'b0, "beq_taken");
    checks++;
    if (imem_addr !== 8'h40) begin errors++; $display("FAIL beq taken target: got %02h expected 40", imem_addr); end
    exec_instr(16'h5240, 0, 0, 1'b0, "cmp_ne");
    beq_pc = m_pc;
    exec_instr(16'h8040, 0, 0, 1'b1, "beq_not_taken");
    checks++;
    if (imem_addr !== beq_pc + 8'd1) begin
      errors++; $display("FAIL beq fallthrough: got %02h expected %02h", imem_addr, beq_pc + 8'd1);
    end
  endtask

  task automatic test_load_wait();
    exec_instr(16'h6E40, 0, 3, 1'b0, "load_wait3");
  endtask

  task automatic test_store();
    exec_instr(16'h7D80, 0, 0, 1'b0, "store");
    exec_instr(16'h7240, 2, 2, 1'b0, "store_wait");
  endtask

  task automatic test_illegal_wrap();
    exec_instr(16'hA000, 0, 0, 1'b0, "illegal_1010");
    exec_instr(16'h90FF, 0, 0, 1'b0, "jmp_ff");
    exec_instr(16'hB123, 0, 0, 1'b0, "nop_at_ff");
    checks++;
    if (imem_addr !== 8'h00) begin errors++; $display("FAIL pc wrap: got %02h expected 00", imem_addr); end
  endtask

  task automatic test_random();
    logic [15:0] instr;
    for (int i = 0; i < 40; i++) begin
      instr = 16'($urandom);
      if (instr[15:12] == 4'hF) instr[15:12] = 4'h0;
      exec_instr(instr, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'($urandom), "random");
    end
  endtask

  task automatic test_halt();
    int bad;
    bad = 0;
    exec_instr(16'hF000, 1, 0, 1'b0, "halt");
    for (int i = 0; i < 20; i++) begin
      imem_ready = 1'($urandom); dmem_ready = 1'($urandom); alu_compare = 1'($urandom);
      if (halted !== 1'b1 || imem_req !== 1'b0 || dmem_req !== 1'b0 || rf_we !== 1'b0 || alu_src !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL halt absorbing: bad cycles=%0d expected 0", bad); end
  endtask

  task automatic test_reset_mid_mem();
    int n;
    rst_n = 1'b0; #3; rst_n = 1'b1;
    m_pc = 8'h00; m_flag = 1'b0;
    @(posedge clk); #1;
    imem_ready = 1'b1; imem_rdata = 16'h6640;
    n = 0;
    while (dmem_req !== 1'b1 && n < 12) begin
      @(posedge clk); #1;
      imem_ready = 1'b0;
      n++;
    end
    checks++;
    if (dmem_req !== 1'b1) begin errors++; $display("FAIL mid-mem setup: dmem_req=%0b expected 1", dmem_req); end
    dmem_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || imem_req !== 1'b0 || alu_src !== 1'b0) begin
      errors++;
      $display("FAIL reset mid-mem: dmem_req=%0b dmem_we=%0b imem_req=%0b alu_src=%0b expected 0", dmem_req, dmem_we, imem_req, alu_src);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      errors++; $display("FAIL post-reset fetch: req=%0b addr=%02h expected 1/00", imem_req, imem_addr);
    end
    exec_instr(16'h06C0, 0, 0, 1'b0, "add_after_reset");
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_load_wait();
    test_store();
    test_illegal_wrap();
    test_random();
    test_halt();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alu_ctrl_fsm
`default_nettype wire
